exc_ctrl: RTL

- Exception/interrupt controller (CP0 subset) for the 5-stage MIPS pipeline.
- Collects the exception code carried to the M stage (from E-stage Ov/AdEL/AdES detection and earlier stages) and samples hardware interrupts.
- Arbitrates exceptions against interrupts and sequences pipeline entry into and exit from the handler (flush plus PC redirect).
- Holds SR, Cause, EPC and PRId for mfc0/mtc0.

---
 rtl/exc_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0-subset exception/interrupt controller for the 5-stage MIPS pipeline.
// Arbitrates M-stage exceptions against hardware interrupts, sequences handler
// entry/exit (flush + PC redirect) and holds SR, Cause, EPC and PRId.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0071
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  exc_code_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        valid_m,
    input  logic [5:0]  hwint,
    input  logic        eret_m,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_SR    = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] ADDR_CAUSE = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] ADDR_EPC   = ADDR_W'(14);
    localparam logic [ADDR_W-1:0] ADDR_PRID  = ADDR_W'(15);
    localparam logic [XLEN-1:0]   WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [INT_W-1:0]    sr_im, sr_im_next;
    logic                sr_exl, sr_exl_next;
    logic                sr_ie, sr_ie_next;
    logic                cause_bd, cause_bd_next;
    logic [INT_W-1:0]    cause_ip;
    logic [CODE_W-1:0]   cause_exc, cause_exc_next;
    logic [XLEN-1:0]     epc, epc_next;
    logic                flush_next;
    logic                redirect_next;
    logic [XLEN-1:0]     redirect_pc_next;

    logic                int_req;
    logic                exc_req;
    logic                take;
    logic                wr_sr;
    logic                wr_epc;
    logic [XLEN-1:0]     pc_adj;

    // Request qualification: both are masked while EXL is set
    assign int_req = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = valid_m & (exc_code_m != CODE_W'(0)) & ~sr_exl;
    assign take    = (state == ST_RUN) & (int_req | exc_req);
    assign wr_sr   = cp0_we & (cp0_addr == ADDR_SR) & ~take;
    assign wr_epc  = cp0_we & (cp0_addr == ADDR_EPC) & ~take;
    assign pc_adj  = bd_m ? (pc_m - XLEN'(4)) : pc_m;
    assign exl     = sr_exl;

    // mfc0 read port: current (pre-write) register contents
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            ADDR_CAUSE: cp0_rdata = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
            ADDR_EPC:   cp0_rdata = epc;
            ADDR_PRID:  cp0_rdata = PRID_VAL;
            default:    cp0_rdata = '0;
        endcase
    end

    // Next-state, register update and redirect generation
    always_comb begin
        state_next       = state;
        sr_im_next       = sr_im;
        sr_exl_next      = sr_exl;
        sr_ie_next       = sr_ie;
        cause_bd_next    = cause_bd;
        cause_exc_next   = cause_exc;
        epc_next         = epc;
        flush_next       = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = '0;

        // mtc0 is dropped in the cycle an exception/interrupt is taken
        if (wr_sr) begin
            sr_im_next  = cp0_wdata[15:10];
            sr_exl_next = cp0_wdata[1];
            sr_ie_next  = cp0_wdata[0];
        end
        if (wr_epc) begin
            epc_next = cp0_wdata & WORD_MASK;
        end

        case (state)
            ST_RUN: begin
                if (take) begin
                    state_next       = ST_ENTER;
                    cause_exc_next   = int_req ? CODE_W'(0) : exc_code_m;
                    cause_bd_next    = bd_m;
                    epc_next         = pc_adj & WORD_MASK;
                    sr_exl_next      = 1'b1;
                    flush_next       = 1'b1;
                    redirect_next    = 1'b1;
                    redirect_pc_next = HANDLER_PC;
                end
            end
            ST_ENTER: begin
                state_next = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret_m && valid_m) begin
                    state_next       = ST_RETURN;
                    sr_exl_next      = 1'b0;
                    flush_next       = 1'b1;
                    redirect_next    = 1'b1;
                    redirect_pc_next = epc_next;
                end else if (wr_sr && !cp0_wdata[1]) begin
                    // software cleared EXL: leave the handler without a redirect
                    state_next = ST_RUN;
                end
            end
            ST_RETURN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State and CP0 registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_RUN;
            sr_im       <= '0;
            sr_exl      <= 1'b0;
            sr_ie       <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ip    <= '0;
            cause_exc   <= '0;
            epc         <= '0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state       <= state_next;
            sr_im       <= sr_im_next;
            sr_exl      <= sr_exl_next;
            sr_ie       <= sr_ie_next;
            cause_bd    <= cause_bd_next;
            cause_ip    <= hwint;
            cause_exc   <= cause_exc_next;
            epc         <= epc_next;
            flush       <= flush_next;
            redirect    <= redirect_next;
            redirect_pc <= redirect_pc_next;
        end
    end

endmodule
